// File: rtl/single_min.sv
// ----------------------------------------------------------------------------
// single_min
//   Registered IEEE-754 binary32 minimum. Each rising edge samples a and b
//   and registers the numerically smaller operand on z. Apart from the
//   NaN cases, the result is always one of the inputs, bit for bit.
//
//   Optional feature macro: SINGLE_MIN_IEEE_NAN_EN
//     defined   : minNum semantics. A single NaN operand is ignored, so the
//                 other operand is returned. Two NaN operands return the
//                 canonical NaN.
//     undefined : any NaN operand produces the canonical NaN (default).
//
// Ports
//   clk  in   1   rising-edge clock
//   rst  in   1   synchronous reset, active-high; forces z to 0
//   a    in  32   operand A, binary32 bit pattern
//   b    in  32   operand B, binary32 bit pattern
//   z    out 32   registered min(a, b)
// ----------------------------------------------------------------------------
module single_min (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  logic        a_sign;
  logic        b_sign;
  logic [7:0]  a_exp;
  logic [7:0]  b_exp;
  logic [22:0] a_man;
  logic [22:0] b_man;
  logic        a_nan;
  logic        b_nan;
  logic        b_less;
  logic [31:0] min_val;
  logic [31:0] result;

  assign a_sign = a[31];
  assign b_sign = b[31];
  assign a_exp  = a[30:23];
  assign b_exp  = b[30:23];
  assign a_man  = a[22:0];
  assign b_man  = b[22:0];

  assign a_nan = (a_exp == 8'hFF) && (a_man != 23'd0);
  assign b_nan = (b_exp == 8'hFF) && (b_man != 23'd0);

  // b_less is true only when b is strictly smaller than a. For bit-identical
  // operands it stays false, so a is returned.
  always_comb begin
    b_less = 1'b0;
    if (a_sign != b_sign) begin
      // With differing signs the negative operand is smaller. This also
      // orders -0 below +0.
      b_less = b_sign;
    end else if (!a_sign) begin
      b_less = (b[30:0] < a[30:0]);
    end else begin
      // For two negative operands, the larger magnitude is the smaller value.
      b_less = (b[30:0] > a[30:0]);
    end
  end

  assign min_val = b_less ? b : a;

  always_comb begin
    result = min_val;
`ifdef SINGLE_MIN_IEEE_NAN_EN
    if (a_nan && b_nan) begin
      result = CANON_NAN;
    end else if (a_nan) begin
      result = b;
    end else if (b_nan) begin
      result = a;
    end
`else
    if (a_nan || b_nan) begin
      result = CANON_NAN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z <= 32'h0000_0000;
    end else begin
      z <= result;
    end
  end

endmodule

// File: tb/tb_single_min.sv
// ----------------------------------------------------------------------------
// tb_single_min
//   Self-checking bench for single_min. Each driven operand pair pushes its
//   expected result into a queue. After the capturing edge, the bench pops
//   that entry and compares it with z. The golden model maps each operand
//   onto an order-preserving unsigned key, which is a different formulation
//   from the sign-case compare used in the RTL.
// ----------------------------------------------------------------------------
module tb_single_min;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  single_min dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .z   (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Order-preserving key: a negative value has all bits inverted, and a
  // positive value has its sign bit set.
  function automatic logic [31:0] order_key(input logic [31:0] v);
    return v[31] ? ~v : {1'b1, v[30:0]};
  endfunction

  function automatic logic [31:0] ref_min(input logic [31:0] x,
                                          input logic [31:0] y);
    logic xn;
    logic yn;
    xn = is_nan(x);
    yn = is_nan(y);
`ifdef SINGLE_MIN_IEEE_NAN_EN
    if (xn && yn) return CANON_NAN;
    if (xn) return y;
    if (yn) return x;
`else
    if (xn || yn) return CANON_NAN;
`endif
    return (order_key(y) < order_key(x)) ? y : x;
  endfunction

  // Drive one cycle: set the inputs away from the edge, queue the expected
  // result, then compare 1 ns after the capturing edge.
  task automatic step(input string tag, input logic r,
                      input logic [31:0] x, input logic [31:0] y);
    logic [31:0] e;
    string       t;
    @(negedge clk);
    rst = r;
    a   = x;
    b   = y;
    exp_q.push_back(r ? 32'h0 : ref_min(x, y));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", z, 32'hDEAD_BEEF);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, z, e);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v = {v[31], 8'hFF, 23'd0};                 // +/- inf
      1: v = {v[31], 8'hFF, v[22:1], 1'b1};         // NaN
      2: v = {v[31], 31'd0};                         // +/- 0
      3: v = {v[31], 8'h00, v[22:0]};               // subnormal
      4: v = {v[31], 8'h7F, v[22:0]};               // near 1.0
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    a   = 32'h0;
    b   = 32'h0;

    step("reset0", 1'b1, 32'h3F80_0000, 32'h4000_0000);
    step("reset1", 1'b1, 32'hBF80_0000, 32'h4000_0000);

    step("pos_1_2",     1'b0, 32'h3F80_0000, 32'h4000_0000);
    check_val("const_pos", z, 32'h3F80_0000);
    step("neg_m2_m1",   1'b0, 32'hC000_0000, 32'hBF80_0000);
    check_val("const_neg", z, 32'hC000_0000);
    step("mixed_1_m1",  1'b0, 32'h3F80_0000, 32'hBF80_0000);
    check_val("const_mixed", z, 32'hBF80_0000);
    step("signed_zero", 1'b0, 32'h0000_0000, 32'h8000_0000);
    check_val("const_szero", z, 32'h8000_0000);
    step("signed_zero_r", 1'b0, 32'h8000_0000, 32'h0000_0000);
    step("equal",       1'b0, 32'h1234_5678, 32'h1234_5678);
    check_val("const_equal", z, 32'h1234_5678);
    step("ninf_vs_max", 1'b0, 32'hFF80_0000, 32'hFF7F_FFFF);
    check_val("const_ninf", z, 32'hFF80_0000);
    step("pinf_vs_max", 1'b0, 32'h7F80_0000, 32'h7F7F_FFFF);
    step("subnormal",   1'b0, 32'h0000_0001, 32'h0000_0002);
    check_val("const_sub", z, 32'h0000_0001);
    step("neg_subnorm", 1'b0, 32'h8000_0001, 32'h8000_0002);
    step("nan_a",       1'b0, 32'h7FC0_0001, 32'h3F80_0000);
`ifdef SINGLE_MIN_IEEE_NAN_EN
    check_val("const_nan_a", z, 32'h3F80_0000);
`else
    check_val("const_nan_a", z, 32'h7FC0_0000);
`endif
    step("nan_b_snan",  1'b0, 32'hBF80_0000, 32'hFF80_0001);
    step("nan_both",    1'b0, 32'h7FC0_0001, 32'hFFA0_0000);
    check_val("const_nan_both", z, 32'h7FC0_0000);

    for (int i = 0; i < 450; i++) begin
      x = rand_operand();
      y = ($urandom_range(0, 15) == 0) ? x : rand_operand();
      if (i == 200) begin
        step("mid_reset", 1'b1, x, y);
      end else begin
        step("stream", 1'b0, x, y);
      end
    end

    if (exp_q.size() != 0) check_val("queue_drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected more", checks);
    $fatal(1);
  end

endmodule
